// File: rtl/rst_seq_pkg.sv
// Shared types and limits for the staggered reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD,
    STEP,
    RUN
  } state_t;

  localparam int unsigned N_CH_MAX = 16;
  // Wide enough to count 0..N_CH_MAX.
  localparam int unsigned IDX_W    = 5;

  function automatic bit cnt_fits(input int unsigned val, input int unsigned width);
    return (64'(val) >> width) == 64'd0;
  endfunction

endpackage

// File: rtl/rst_seq_if.sv
// Request/status bundle between the reset sequencer and its controller.
interface rst_seq_if #(
  parameter int unsigned N_CH = 3
);
  logic            SwRst_req;
  logic            Kick;
  logic [N_CH-1:0] Rst_n_o;
  logic            Busy;
  logic            Done;
  logic            WdogEvt;

  modport master (
    output SwRst_req,
    output Kick,
    input  Rst_n_o,
    input  Busy,
    input  Done,
    input  WdogEvt
  );

  modport slave (
    input  SwRst_req,
    input  Kick,
    output Rst_n_o,
    output Busy,
    output Done,
    output WdogEvt
  );
endinterface

// File: rtl/rst_seq_cnt.sv
// Up-counter with synchronous clear and enable; tc flags the edge on which the
// count would reach lim, and the counter reloads to zero on that edge.
module rst_seq_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] lim,
  output logic             tc
);
  logic [CNT_W-1:0] cnt;

  assign tc = en && (cnt == lim - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/rst_seq.sv
// Staggered reset sequencer: holds all channels, then releases them one by one.
// Optional watchdog re-sequence is built only when RST_SEQ_WDOG_EN is defined.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned N_CH     = 3,
  parameter int unsigned HOLD_CYC = 16,
  parameter int unsigned STEP_CYC = 8,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned WDOG_CYC = 200
) (
  input  logic        Clk,
  input  logic        Rst,
  rst_seq_if.slave    bus
);

  if (N_CH < 1 || N_CH > N_CH_MAX || HOLD_CYC < 1 || STEP_CYC < 1 ||
      !cnt_fits(HOLD_CYC, CNT_W) || !cnt_fits(STEP_CYC, CNT_W) ||
      !cnt_fits(WDOG_CYC, CNT_W)) begin : g_bad_param
    $error("rst_seq: illegal parameter set");
  end

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [N_CH-1:0]  rst_n;
  logic             busy;
  logic             done;

  logic             restart;
  logic             wdog_fire;
  logic             tmr_en;
  logic             tmr_clr;
  logic             tmr_tc;
  logic [CNT_W-1:0] tmr_lim;

  assign restart = Rst || bus.SwRst_req || wdog_fire;
  assign tmr_en  = (state != RUN);
  assign tmr_clr = restart || (state == RUN);
  assign tmr_lim = (state == HOLD) ? CNT_W'(HOLD_CYC) : CNT_W'(STEP_CYC);

  rst_seq_cnt #(.CNT_W(CNT_W)) u_tmr (
    .clk (Clk),
    .clr (tmr_clr),
    .en  (tmr_en),
    .lim (tmr_lim),
    .tc  (tmr_tc)
  );

`ifdef RST_SEQ_WDOG_EN
  logic wd_en;
  logic wd_clr;
  logic wd_tc;
  logic wdog_evt;

  assign wd_en     = (state == RUN);
  assign wd_clr    = Rst || bus.Kick || !wd_en;
  // A kick on the expiry edge suppresses the event.
  assign wdog_fire = wd_tc && !bus.Kick && !Rst;

  rst_seq_cnt #(.CNT_W(CNT_W)) u_wdog (
    .clk (Clk),
    .clr (wd_clr),
    .en  (wd_en),
    .lim (CNT_W'(WDOG_CYC)),
    .tc  (wd_tc)
  );

  always_ff @(posedge Clk) begin
    if (Rst) wdog_evt <= 1'b0;
    else     wdog_evt <= wdog_fire;
  end

  assign bus.WdogEvt = wdog_evt;
`else
  assign wdog_fire   = 1'b0;
  assign bus.WdogEvt = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (restart) begin
      state <= HOLD;
      idx   <= '0;
      rst_n <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (tmr_tc) begin
            rst_n[0] <= 1'b1;
            idx      <= IDX_W'(1);
            if (N_CH == 1) begin
              state <= RUN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= STEP;
            end
          end
        end
        STEP: begin
          if (tmr_tc) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
              if (idx == IDX_W'(i)) rst_n[i] <= 1'b1;
            end
            idx <= idx + IDX_W'(1);
            if (idx == IDX_W'(N_CH - 1)) begin
              state <= RUN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        RUN: ;
        default: begin
          state <= HOLD;
          idx   <= '0;
          rst_n <= '0;
          busy  <= 1'b1;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Rst_n_o = rst_n;
  assign bus.Busy    = busy;
  assign bus.Done    = done;

endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
- Synthesizable reset sequencer for the WM8731 codec controller.
- Replaces the single behavioural reset level with N_CH active-low reset outputs, one per downstream domain: I2C/control, audio interface, DSP path.
- After a minimum hold period, releases the outputs one at a time in a fixed, staggered order.
- Supports a software-requested full re-sequence, and optionally a watchdog-triggered one.

Parameters:
- N_CH, 3, number of reset outputs; legal range 1..16.
- HOLD_CYC, 16, cycles all outputs stay asserted after reset/request ends; must be >=1.
- STEP_CYC, 8, cycles between release of consecutive channels; must be >=1.
- CNT_W, 8, counter width; must hold max(HOLD_CYC, STEP_CYC, WDOG_CYC).
- WDOG_CYC, 200, watchdog timeout in cycles; used only with RST_SEQ_WDOG_EN.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  synchronous, active-high reset.
- SwRst_req  in  1  software re-sequence request; level-sampled each cycle.
- Kick  in  1  watchdog service pulse.
- Rst_n_o  out  N_CH  per-channel reset, active-low; bit 0 is released first.
- Busy  out  1  high while any channel is still held.
- Done  out  1  high when all channels are released.
- WdogEvt  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- One clock, Clk. Reset is synchronous and active-high: Rst is sampled only on Clk rising edges, and Rst=1 has priority over every other input.
- While Rst=1:
  - Rst_n_o = all 0, Busy=1, Done=0, WdogEvt=0.
  - State = HOLD, counter = 0, channel index = 0.
- States: HOLD, STEP, RUN.
- Edge numbering: edge 1 is the first rising edge with Rst=0.
- HOLD:
  - Counter increments each edge.
  - On edge HOLD_CYC: Rst_n_o[0] becomes 1, counter clears, index becomes 1.
  - Next state is STEP, or RUN if N_CH=1.
- STEP:
  - Counter increments each edge.
  - When it reaches STEP_CYC: Rst_n_o[index] becomes 1, counter clears, index increments.
  - When the last channel is released, next state is RUN.
- Required release timing (no SwRst_req in between):
  - Rst_n_o[k] rises on edge HOLD_CYC + k*STEP_CYC.
  - Done rises and Busy falls on the same edge as Rst_n_o[N_CH-1].
- Released channels stay 1 until the next Rst or re-sequence; there is no partial re-assertion.
- RUN: outputs stable; Busy=0, Done=1.
- SwRst_req=1 on an edge, in any state, with Rst=0:
  - The same edge sets all Rst_n_o to 0, Busy=1, Done=0, state HOLD, counter 0, index 0.
  - This applies mid-STEP as well: the whole sequence restarts from the beginning.
  - If SwRst_req is held high, the block stays in HOLD with counter 0.
  - HOLD_CYC counting starts on the first edge with SwRst_req=0; the timing rule above then applies with that edge as edge 1.
- Counters saturate/clear cleanly; no wrap-around is reachable, given CNT_W is legal.
- Outputs are registered, with no combinational path from inputs to outputs.

Optional Feature:
- Macro: RST_SEQ_WDOG_EN.
- Defined:
  - In RUN, the watchdog counter increments each edge and clears on Kick=1.
  - On reaching WDOG_CYC, WdogEvt=1 for exactly one cycle, and on that same edge the block re-sequences exactly as for SwRst_req.
  - Kick and expiry on the same edge: Kick wins and there is no event.
  - Outside RUN, the watchdog counter is held at 0.
- Undefined: Kick is ignored, WdogEvt is tied 0, and no watchdog counter is synthesized.

Decomposition:
- Package rst_seq_pkg:
  - state enum (HOLD, STEP, RUN);
  - localparam limits N_CH_MAX=16;
  - width-check helper function.
- Sub-module rst_seq_cnt: CNT_W-bit counter with synchronous clear, enable and terminal-count compare. Instantiated for the hold/step timer, and for the watchdog when enabled.

Test Plan (defaults unless noted):
- Power-up: Rst=1 for 5 cycles, then 0 -> Rst_n_o=000 until edge 16; bit0 at edge 16, bit1 at edge 24, bit2 at edge 32; Done=1 and Busy=0 at edge 32.
- Rst=1 asserted at edge 20, mid-sequence -> next edge Rst_n_o=000, Done=0; after release, timing restarts exactly as in the power-up test.
- SwRst_req pulse for 1 cycle in RUN -> same edge Rst_n_o=000, Busy=1; bit0 returns 16 edges after the request drops.
- SwRst_req held 10 cycles during STEP -> outputs 000 throughout; release timing counted from the first low edge.
- N_CH=1, HOLD_CYC=1 -> Rst_n_o[0] and Done rise on edge 1.
- With RST_SEQ_WDOG_EN and WDOG_CYC=20:
  - no Kick -> WdogEvt pulses 1 cycle 20 edges into RUN and a re-sequence starts;
  - Kick every 10 cycles -> no event;
  - Kick on the expiry edge -> no event.
